// File: rtl/spi_master_pkg.sv
// Shared types and default sizing for the SPI master core.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int SPI_DATA_W_DEF  = 8;
    localparam int SPI_CLK_DIV_DEF = 4;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider: while enabled, strobes tick once every CLK_DIV clk cycles,
// the first strobe landing CLK_DIV cycles after enable rises.
module spi_clk_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = en && (cnt == LAST_CNT);

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master, MSB first, single slave, registered outputs.
// Define SPI_MASTER_LOOPBACK_EN to receive the core's own mosi instead of miso.
module spi_master_core
    import spi_master_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W_DEF,
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              cs_b,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

    spi_state_t        state, state_nxt;
    logic              tick;
    logic              accept, rise_evt, fall_evt, last_fall, hold_end;
    logic [5:0]        bit_cnt;
    logic [DATA_W-1:0] tx_shift, tx_next, rx_shift;
    logic              rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = mosi;
`else
    assign rx_bit = miso;
`endif

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The SETUP->XFER strobe doubles as the first sclk rise.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rise_evt  = 1'b0;
        fall_evt  = 1'b0;
        last_fall = 1'b0;
        hold_end  = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: if (tick) begin
                rise_evt  = 1'b1;
                state_nxt = XFER;
            end
            XFER: if (tick) begin
                if (sclk) begin
                    fall_evt = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        last_fall = 1'b1;
                        state_nxt = HOLD;
                    end
                end else begin
                    rise_evt = 1'b1;
                end
            end
            HOLD: if (tick) begin
                hold_end  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_next = tx_shift << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_b    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cs_b    <= 1'b0;
                busy    <= 1'b1;
                mosi    <= tx_data[DATA_W-1];
                bit_cnt <= '0;
            end
            if (rise_evt) sclk <= 1'b1;
            // mosi holds the final bit through HOLD
            if (fall_evt) begin
                sclk <= 1'b0;
                if (!last_fall) begin
                    mosi    <= tx_next[DATA_W-1];
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
            if (hold_end) begin
                cs_b    <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                mosi    <= 1'b0;
                rx_data <= rx_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)        tx_shift <= tx_data;
        else if (fall_evt) tx_shift <= tx_next;
        if (rise_evt)      rx_shift <= (rx_shift << 1) | DATA_W'(rx_bit);
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: default instance with a mode-0 slave model,
// plus a CLK_DIV=1 instance whose miso is wired back to its own mosi.
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, done, cs_b, sclk, mosi;
    logic       miso = 1'b0;

    logic       start_b = 1'b0;
    logic [7:0] tx_b = 8'h00;
    logic [7:0] rx_b;
    logic       busy_b, done_b, cs_b_b, sclk_b, mosi_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int s_cyc = 0;

    // Bench-side observers, written only by the monitor process
    int         rise_cnt = 0, done_cnt = 0, done_cyc = 0;
    int         hi_run = 0, last_gap = 0, rise_b = 0;
    logic [7:0] mosi_cap = 8'h00, sl_sh = 8'h00, slave_tx = 8'h00;
    logic       prev_sclk = 1'b0, prev_sclk_b = 1'b0;

    spi_master_core u_dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
        .busy(busy), .done(done), .cs_b(cs_b), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    spi_master_core #(.DATA_W(8), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .rx_data(rx_b),
        .busy(busy_b), .done(done_b), .cs_b(cs_b_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(mosi_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and mode-0 slave: shifts out slave_tx MSB first, next bit after each sclk fall
    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            rise_cnt <= rise_cnt + 1;
            mosi_cap <= {mosi_cap[6:0], mosi};
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (cs_b) hi_run <= hi_run + 1;
        else if (hi_run != 0) begin
            last_gap <= hi_run;
            hi_run   <= 0;
        end
        if (cs_b) begin
            sl_sh <= slave_tx;
            miso  <= slave_tx[7];
        end else if (!sclk && prev_sclk) begin
            sl_sh <= sl_sh << 1;
            miso  <= sl_sh[6];
        end
        prev_sclk <= sclk;
        if (sclk_b && !prev_sclk_b) rise_b <= rise_b + 1;
        prev_sclk_b <= sclk_b;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        tx_data = d;
        start   = 1'b1;
        s_cyc   = cyc;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cs_b"}, cs_b, 1'b1);
        check({tag, "_sclk"}, sclk, 1'b0);
        check({tag, "_mosi"}, mosi, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_rx"}, rx_data, 8'h00);
    endtask

    initial begin
        int r0, d0, k;

        repeat (3) tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // Single frame 0xA5 against slave 0x3C
        slave_tx = 8'h3C;
        tick();
        r0 = rise_cnt;
        start_frame(8'hA5);
        check("f1_c1_cs_b", cs_b, 1'b0);
        check("f1_c1_busy", busy, 1'b1);
        check("f1_c1_mosi", mosi, 1'b1);
        repeat (3) tick();
        check("f1_c4_sclk", sclk, 1'b0);
        tick();
        check("f1_c5_sclk", sclk, 1'b1);
        wait_done("f1_done");
        check("f1_done_cyc", done_cyc - s_cyc, 69);
        check("f1_pulses", rise_cnt - r0, 8);
        check("f1_mosi_bits", mosi_cap, 8'hA5);
        check("f1_rx", rx_data, 8'h3C);
        check("f1_cs_b_up", cs_b, 1'b1);
        check("f1_busy_low", busy, 1'b0);
        tick();
        check("f1_done_1cyc", done, 1'b0);
        check("f1_sclk_idle", sclk, 1'b0);

        // Start during a frame is ignored
        slave_tx = 8'hC3;
        tick();
        d0 = done_cnt;
        start_frame(8'h81);
        repeat (9) tick();
        tx_data = 8'hFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("ig_done");
        check("ig_done_cyc", done_cyc - s_cyc, 69);
        check("ig_mosi_bits", mosi_cap, 8'h81);
        check("ig_rx", rx_data, 8'hC3);
        repeat (80) tick();
        check("ig_one_done", done_cnt - d0, 1);
        check("ig_busy", busy, 1'b0);

        // Back-to-back frames, second start on the done cycle
        slave_tx = 8'h9E;
        tick();
        start_frame(8'h12);
        repeat (20) tick();
        slave_tx = 8'h6B;
        wait_done("bb1_done");
        check("bb1_mosi_bits", mosi_cap, 8'h12);
        check("bb1_rx", rx_data, 8'h9E);
        start_frame(8'h34);
        check("bb2_cs_b", cs_b, 1'b0);
        check("bb_gap", last_gap, 1);
        wait_done("bb2_done");
        check("bb2_done_cyc", done_cyc - s_cyc, 69);
        check("bb2_mosi_bits", mosi_cap, 8'h34);
        check("bb2_rx", rx_data, 8'h6B);

        // Reset at cycle 30 aborts the frame
        tick();
        d0 = done_cnt;
        start_frame(8'hF0);
        repeat (29) tick();
        check("ab_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_reset("ab");
        tick();
        tick();
        rst = 1'b0;
        repeat (100) tick();
        check("ab_no_done", done_cnt - d0, 0);

        slave_tx = 8'h5C;
        tick();
        r0 = rise_cnt;
        start_frame(8'h3C);
        wait_done("rc_done");
        check("rc_done_cyc", done_cyc - s_cyc, 69);
        check("rc_pulses", rise_cnt - r0, 8);
        check("rc_mosi_bits", mosi_cap, 8'h3C);
        check("rc_rx", rx_data, 8'h5C);

        // CLK_DIV=1 instance with mosi looped to miso
        tick();
        r0      = rise_b;
        tx_b    = 8'h5A;
        start_b = 1'b1;
        s_cyc   = cyc;
        tick();
        start_b = 1'b0;
        check("lb_c1_sclk", sclk_b, 1'b0);
        check("lb_c1_mosi", mosi_b, 1'b0);
        tick();
        check("lb_c2_sclk", sclk_b, 1'b1);
        tick();
        check("lb_c3_sclk", sclk_b, 1'b0);
        k = 0;
        while (!done_b && k < 50) begin
            tick();
            k++;
        end
        check("lb_done", done_b, 1'b1);
        check("lb_done_cyc", cyc - s_cyc, 18);
        check("lb_pulses", rise_b - r0, 8);
        check("lb_rx", rx_b, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
